// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, port IDs and
// arbiter state encoding.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    // Identifies which requester a read tag belongs to.
    typedef logic port_id_t;
    localparam port_id_t PORT_A = 1'b0;
    localparam port_id_t PORT_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Fixed-latency read tag pipeline. Each launched read enters a {valid, port}
// tag at the head; the tag reaches the tail when its SRAM data is ready to
// be captured. An asynchronous clear drops every in-flight tag.
module sram_rd_tag_pipe
    import sram_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_valid_i,
    input  port_id_t push_port_i,
    output logic     tail_valid_o,
    output port_id_t tail_port_o
);

    logic     vld_q  [RD_LAT];
    port_id_t port_q [RD_LAT];

    // Shift tags one stage per clock; reset flushes the whole pipe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                port_q[i] <= PORT_A;
            end
        end else begin
            vld_q[0]  <= push_valid_i;
            port_q[0] <= push_port_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                port_q[i] <= port_q[i-1];
            end
        end
    end

    assign tail_valid_o = vld_q[RD_LAT-1];
    assign tail_port_o  = port_q[RD_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: read-only stream port A has priority over
// read/write port B, with a bounded A run while B waits and a one-cycle
// bubble whenever a write is followed by a read.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no access was granted in the previous cycle
// ST_ISSUE | a read was granted in the previous cycle
// ST_TURN  | a write was granted in the previous cycle; only another
//          | write may be granted now, anything else makes this a bubble
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int AW        = SRAM_AW,
    parameter int DW        = SRAM_DW,
    parameter int RD_LAT    = 2,
    parameter int A_MAX_RUN = 8
) (
    input  logic          clk_100,
    input  logic          sys_reset_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    output logic          a_ready,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] ramctl_read_address,
    output logic [AW-1:0] ramctl_write_address,
    output logic          ramctl_write,
    output logic [DW-1:0] ramctl_data_in,
    input  logic [DW-1:0] ramctl_data_out
);

    localparam int              RW        = $clog2(A_MAX_RUN + 1);
    localparam logic [RW-1:0]   RUN_LIMIT = RW'(A_MAX_RUN);

    arb_state_e    state_q, state_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          starve, a_pick, b_pick;
    logic          grant_a, grant_b;
    logic          rd_issue_q;
    port_id_t      rd_port_q;
    logic          tag_valid;
    port_id_t      tag_port;

    // Grant decision, next state and A-run counter update.
    always_comb begin
        state_d   = ST_IDLE;
        run_cnt_d = run_cnt_q;
        grant_a   = 1'b0;
        grant_b   = 1'b0;

        starve = b_valid && (run_cnt_q == RUN_LIMIT);
        a_pick = a_valid && !starve;
        b_pick = b_valid && !a_pick;

        // Grants are held off while reset is asserted so ready stays low.
        if (sys_reset_n) begin
            case (state_q)
                ST_TURN: grant_b = b_pick && b_we;
                default: begin
                    grant_a = a_pick;
                    grant_b = b_pick;
                end
            endcase
        end

        if (grant_b && b_we) begin
            state_d = ST_TURN;
        end else if (grant_a || grant_b) begin
            state_d = ST_ISSUE;
        end

        if (grant_b || !b_valid) begin
            run_cnt_d = '0;
        end else if (grant_a && (run_cnt_q != RUN_LIMIT)) begin
            run_cnt_d = run_cnt_q + RW'(1);
        end

        a_ready = grant_a;
        b_ready = grant_b;
    end

    // State, counter and registered SRAM command outputs.
    always_ff @(posedge clk_100 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q              <= ST_IDLE;
            run_cnt_q            <= '0;
            ramctl_read_address  <= '0;
            ramctl_write_address <= '0;
            ramctl_write         <= 1'b0;
            ramctl_data_in       <= '0;
            rd_issue_q           <= 1'b0;
            rd_port_q            <= PORT_A;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            ramctl_write <= grant_b && b_we;
            // The read address only moves on a real read, so idle cycles
            // repeat a harmless read of the previous location.
            if (grant_a) begin
                ramctl_read_address <= a_addr;
            end else if (grant_b && !b_we) begin
                ramctl_read_address <= b_addr;
            end
            if (grant_b && b_we) begin
                ramctl_write_address <= b_addr;
                ramctl_data_in       <= b_wdata;
            end
            rd_issue_q <= grant_a || (grant_b && !b_we);
            rd_port_q  <= grant_a ? PORT_A : PORT_B;
        end
    end

    // The tag enters the pipe aligned with the launched read address.
    sram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk_i        (clk_100),
        .rst_ni       (sys_reset_n),
        .push_valid_i (rd_issue_q),
        .push_port_i  (rd_port_q),
        .tail_valid_o (tag_valid),
        .tail_port_o  (tag_port)
    );

    // Capture returning SRAM data into the port that issued the read.
    always_ff @(posedge clk_100 or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= tag_valid && (tag_port == PORT_A);
            b_rvalid <= tag_valid && (tag_port == PORT_B);
            if (tag_valid && (tag_port == PORT_A)) begin
                a_rdata <= ramctl_data_out;
            end
            if (tag_valid && (tag_port == PORT_B)) begin
                b_rdata <= ramctl_data_out;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a simple SRAM model behind the ramctl interface,
// a reference memory plus per-port expected-read queues, directed steps
// followed by a randomized phase.
module tb_sram_arbiter;

    localparam int AW        = 18;
    localparam int DW        = 16;
    localparam int A_MAX_RUN = 8;
    localparam int LAT_EDGES = 3;              // accept edge to rvalid edge
    localparam int B_WAIT_MAX = A_MAX_RUN + 1; // 8 A grants plus one bubble

    logic          clk_100;
    logic          sys_reset_n;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic          a_ready;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_valid;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ready;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ramctl_read_address;
    logic [AW-1:0] ramctl_write_address;
    logic          ramctl_write;
    logic [DW-1:0] ramctl_data_in;
    logic [DW-1:0] ramctl_data_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int a_rv_cnt = 0;
    bit [15:0] seed;

    // SRAM model state (written only by the model process).
    bit [15:0] sram_mem [0:1023];
    bit        sram_wr  [0:1023];
    logic [15:0] rd_s1;

    // Reference model state.
    bit [15:0] ref_mem [0:1023];
    bit        ref_wr  [0:1023];
    logic [15:0] qa_data[$];
    int          qa_due[$];
    logic [15:0] qb_data[$];
    int          qb_due[$];

    sram_arbiter dut (
        .clk_100              (clk_100),
        .sys_reset_n          (sys_reset_n),
        .a_valid              (a_valid),
        .a_addr               (a_addr),
        .a_ready              (a_ready),
        .a_rvalid             (a_rvalid),
        .a_rdata              (a_rdata),
        .b_valid              (b_valid),
        .b_we                 (b_we),
        .b_addr               (b_addr),
        .b_wdata              (b_wdata),
        .b_ready              (b_ready),
        .b_rvalid             (b_rvalid),
        .b_rdata              (b_rdata),
        .ramctl_read_address  (ramctl_read_address),
        .ramctl_write_address (ramctl_write_address),
        .ramctl_write         (ramctl_write),
        .ramctl_data_in       (ramctl_data_in),
        .ramctl_data_out      (ramctl_data_out)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    // Power-up contents: distinct per address, seeded per run.
    function automatic bit [15:0] init_val(input logic [9:0] a);
        return (16'(a) * 16'h9E37) ^ seed;
    endfunction

    function automatic logic [15:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a[9:0]] ? ref_mem[a[9:0]] : init_val(a[9:0]);
    endfunction

    function automatic logic [AW-1:0] rnd_addr(input int base, input int span);
        return AW'(base + $urandom_range(0, span - 1));
    endfunction

    // SRAM: write commits one edge after launch; read data is valid two
    // edges after the address is launched.
    always @(posedge clk_100) begin
        if (ramctl_write) begin
            sram_mem[ramctl_write_address[9:0]] <= ramctl_data_in;
            sram_wr[ramctl_write_address[9:0]]  <= 1'b1;
        end
        rd_s1 <= sram_wr[ramctl_read_address[9:0]] ? sram_mem[ramctl_read_address[9:0]]
                                                    : init_val(ramctl_read_address[9:0]);
        ramctl_data_out <= rd_s1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return {a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata,
                ramctl_read_address, ramctl_write_address, ramctl_write, ramctl_data_in};
    endfunction

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic drive_idle();
        a_valid = 1'b0;
        b_valid = 1'b0;
        b_we    = 1'b0;
    endtask

    task automatic wait_rv(input bit port_b, input int max_cyc);
        int k = 0;
        do begin
            @(negedge clk_100);
            k++;
        end while (!(port_b ? b_rvalid : a_rvalid) && k < max_cyc);
        if (port_b) chk("b_rvalid_seen", b_rvalid, 1);
        else        chk("a_rvalid_seen", a_rvalid, 1);
    endtask

    task automatic drain();
        int k = 0;
        while ((qa_due.size() != 0 || qb_due.size() != 0) && k < 20) begin
            @(negedge clk_100);
            #1;
            k++;
        end
        chk("drain_done", (qa_due.size() == 0) && (qb_due.size() == 0), 1);
    endtask

    // Monitor: protocol rules, reference model updates, read return scoreboard.
    initial begin
        bit prev_b_wr = 1'b0;
        int b_wait    = 0;
        logic [15:0] exp_d;
        int          exp_c;
        forever begin
            @(negedge clk_100);
            if (!sys_reset_n) begin
                prev_b_wr = 1'b0;
                b_wait    = 0;
                continue;
            end
            chk("single_grant", a_ready & b_ready, 0);
            if (prev_b_wr) begin
                chk("no_read_after_write", a_ready | (b_ready & ~b_we), 0);
            end else if (a_valid || b_valid) begin
                chk("work_conserving", a_ready | b_ready, 1);
            end
            if (b_valid && !b_ready) b_wait++;
            if (b_valid && b_ready) begin
                chk("b_wait_bound", b_wait <= B_WAIT_MAX, 1);
                b_wait = 0;
            end
            if (!b_valid) b_wait = 0;

            if (a_valid && a_ready) begin
                qa_data.push_back(ref_read(a_addr));
                qa_due.push_back(cyc + 1 + LAT_EDGES);
            end
            if (b_valid && b_ready) begin
                if (b_we) begin
                    ref_mem[b_addr[9:0]] = b_wdata;
                    ref_wr[b_addr[9:0]]  = 1'b1;
                end else begin
                    qb_data.push_back(ref_read(b_addr));
                    qb_due.push_back(cyc + 1 + LAT_EDGES);
                end
            end
            prev_b_wr = b_valid && b_ready && b_we;

            if (a_rvalid) begin
                a_rv_cnt++;
                chk("a_rvalid_expected", qa_due.size() != 0, 1);
                if (qa_due.size() != 0) begin
                    exp_d = qa_data.pop_front();
                    exp_c = qa_due.pop_front();
                    chk("a_rdata", a_rdata, exp_d);
                    chk("a_latency", cyc, exp_c);
                end
            end
            if (b_rvalid) begin
                chk("b_rvalid_expected", qb_due.size() != 0, 1);
                if (qb_due.size() != 0) begin
                    exp_d = qb_data.pop_front();
                    exp_c = qb_due.pop_front();
                    chk("b_rdata", b_rdata, exp_d);
                    chk("b_latency", cyc, exp_c);
                end
            end
        end
    end

    // Directed steps followed by a randomized phase.
    initial begin
        logic [15:0]   w202;
        logic [AW-1:0] ra;
        int            rv_start;
        bit            a_acc, b_acc;

        seed        = 16'($urandom);
        sys_reset_n = 1'b0;
        drive_idle();
        a_addr  = '0;
        b_addr  = '0;
        b_wdata = '0;

        // Reset values, then 20 idle cycles with everything at zero.
        @(negedge clk_100);
        chk("reset_outputs", all_outputs(), 0);
        tick();
        tick();
        sys_reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_100);
            chk("idle_outputs", all_outputs(), 0);
        end

        // B write 0x10 <- 0xBEEF, then B read 0x10 across one bubble.
        tick();
        b_valid = 1'b1; b_we = 1'b1; b_addr = 18'h00010; b_wdata = 16'hBEEF;
        @(negedge clk_100);
        chk("wr_ready", b_ready, 1);
        tick();
        b_we = 1'b0; b_wdata = 16'($urandom);
        @(negedge clk_100);
        chk("turn_b_ready", b_ready, 0);
        chk("turn_write_launched", ramctl_write, 1);
        tick();
        @(negedge clk_100);
        chk("rd_ready_after_turn", b_ready, 1);
        chk("turn_write_low", ramctl_write, 0);
        tick();
        drive_idle();
        wait_rv(1'b1, 10);
        chk("beef_readback", b_rdata, 16'hBEEF);
        drain();

        // A streams 0x100..0x10F back to back.
        rv_start = a_rv_cnt;
        tick();
        a_valid = 1'b1; a_addr = 18'h00100;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100);
            chk("a_stream_ready", a_ready, 1);
            tick();
            if (i == 15) a_valid = 1'b0;
            else         a_addr  = AW'(32'h100 + i + 1);
        end
        drain();
        chk("a_stream_count", a_rv_cnt - rv_start, 16);

        // Starvation bound: A continuous with B read pending.
        tick();
        a_valid = 1'b1; a_addr = rnd_addr(0, 1024);
        b_valid = 1'b1; b_we = 1'b0; b_addr = rnd_addr(0, 1024);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk_100);
            chk("starve_a_ready", a_ready, (k == 8 || k == 17) ? 0 : 1);
            chk("starve_b_ready", b_ready, (k == 8 || k == 17) ? 1 : 0);
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
            tick();
            if (a_acc) a_addr = rnd_addr(0, 1024);
            if (b_acc) b_addr = rnd_addr(0, 1024);
        end
        drive_idle();
        drain();

        // B write burst 0x200..0x203, then an A read of 0x202.
        w202 = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                b_valid = 1'b1; b_we = 1'b1;
                b_addr  = AW'(32'h200 + k);
                b_wdata = 16'($urandom);
                if (k == 2) w202 = b_wdata;
            end else begin
                b_valid = 1'b0; b_we = 1'b0;
                a_valid = 1'b1; a_addr = 18'h00202;
            end
            @(negedge clk_100);
            chk("burst_b_ready", b_ready, (k < 4) ? 1 : 0);
            chk("burst_a_ready", a_ready, (k == 5) ? 1 : 0);
            chk("burst_write", ramctl_write, (k >= 1 && k <= 4) ? 1 : 0);
        end
        tick();
        drive_idle();
        wait_rv(1'b0, 10);
        chk("burst_readback", a_rdata, w202);
        drain();

        // Reset with two A reads in flight.
        tick();
        a_valid = 1'b1; a_addr = rnd_addr(0, 1024);
        @(negedge clk_100);
        chk("pre_rst_ready0", a_ready, 1);
        tick();
        a_addr = rnd_addr(0, 1024);
        @(negedge clk_100);
        chk("pre_rst_ready1", a_ready, 1);
        tick();
        drive_idle();
        sys_reset_n = 1'b0;
        qa_data.delete(); qa_due.delete();
        qb_data.delete(); qb_due.delete();
        @(negedge clk_100);
        chk("mid_rst_outputs", all_outputs(), 0);
        tick();
        sys_reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_100);
            chk("rst_no_a_rvalid", a_rvalid, 0);
            chk("rst_no_b_rvalid", b_rvalid, 0);
        end
        tick();
        ra = rnd_addr(0, 1024);
        a_valid = 1'b1; a_addr = ra;
        @(negedge clk_100);
        chk("post_rst_ready", a_ready, 1);
        tick();
        drive_idle();
        wait_rv(1'b0, 10);
        chk("post_rst_data", a_rdata, ref_read(ra));
        drain();

        // Randomized traffic on a small shared address window.
        a_acc = 1'b0;
        b_acc = 1'b0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!a_valid || a_acc) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_addr  = rnd_addr(32'h300, 32);
            end
            if (!b_valid || b_acc) begin
                b_valid = ($urandom_range(0, 99) < 50);
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = rnd_addr(32'h300, 16);
                b_wdata = 16'($urandom);
            end
            @(negedge clk_100);
            a_acc = a_valid && a_ready;
            b_acc = b_valid && b_ready;
        end
        tick();
        drive_idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
